// File: rtl/mc_control_if.sv
// Control bundle between the multi-cycle sequencer and the RISC-V datapath/debug unit.
// The master side is the sequencer; the slave side is the datapath it steers.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic [6:0]       opcode;
    logic             zero;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic [1:0]       alu_a;
    logic [1:0]       alu_b;
    logic [1:0]       alu_op;
    logic             mem_we;
    logic             rf_we;
    logic [1:0]       rf_src;
    logic             busy;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] icount;
    logic [3:0]       state;

    modport master (
        input  run, step, opcode, zero,
        output ir_we, pc_we, pc_src, alu_a, alu_b, alu_op, mem_we, rf_we, rf_src,
        output busy, instr_done, illegal, icount, state
    );

    modport slave (
        output run, step, opcode, zero,
        input  ir_we, pc_we, pc_src, alu_a, alu_b, alu_op, mem_we, rf_we, rf_src,
        input  busy, instr_done, illegal, icount, state
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle sequencer for the add/addi/lw/sw/beq/jal datapath, with run/step
// debug control, a retired-instruction counter and a sticky illegal-opcode halt.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mc_control_if.master ctl
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EX_R     = 4'd3,
        EX_I     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_ALU   = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JAL      = 4'd11,
        HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t           state_q, state_d;
    logic             step_pend_q, step_pend_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] icount_q;
    logic             busy;
    logic             done;

    assign busy = !(state_q inside {IDLE, HALT});
    assign done = state_q inside {WB_ALU, WB_MEM, MEM_WR, BRANCH, JAL};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            step_pend_q <= 1'b0;
            illegal_q   <= 1'b0;
            icount_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_pend_q <= step_pend_d;
            illegal_q   <= illegal_d;
            if (done)
                icount_q <= icount_q + CNT_W'(1);
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            IDLE: begin
                if (ctl.run || ctl.step || step_pend_q)
                    state_d = FETCH;
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                unique case (ctl.opcode)
                    OP_R:         state_d = EX_R;
                    OP_I:         state_d = EX_I;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EX_R, EX_I: state_d = WB_ALU;
            MEM_ADDR:   state_d = (ctl.opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:     state_d = WB_MEM;
            WB_ALU, WB_MEM, MEM_WR, BRANCH, JAL:
                state_d = (ctl.run || step_pend_q) ? FETCH : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // A pending step is consumed by any transition into FETCH; a new pulse while busy wins.
    always_comb begin : step_pending
        step_pend_d = step_pend_q;
        if (state_d == FETCH)
            step_pend_d = 1'b0;
        if (ctl.step && busy)
            step_pend_d = 1'b1;
    end

    always_comb begin : strobes
        ctl.ir_we  = 1'b0;
        ctl.pc_we  = 1'b0;
        ctl.pc_src = 1'b0;
        ctl.alu_a  = 2'd0;
        ctl.alu_b  = 2'd0;
        ctl.alu_op = 2'b00;
        ctl.mem_we = 1'b0;
        ctl.rf_we  = 1'b0;
        ctl.rf_src = 2'd0;
        unique case (state_q)
            FETCH: begin
                ctl.ir_we = 1'b1;
                ctl.alu_b = 2'd1;
                ctl.pc_we = 1'b1;
            end
            DECODE: begin
                ctl.alu_a = 2'd2;
                ctl.alu_b = 2'd3;
            end
            EX_R: begin
                ctl.alu_a  = 2'd1;
                ctl.alu_op = 2'b10;
            end
            EX_I: begin
                ctl.alu_a  = 2'd1;
                ctl.alu_b  = 2'd2;
                ctl.alu_op = 2'b10;
            end
            MEM_ADDR: begin
                ctl.alu_a = 2'd1;
                ctl.alu_b = 2'd2;
            end
            MEM_WR: ctl.mem_we = 1'b1;
            WB_ALU: ctl.rf_we = 1'b1;
            WB_MEM: begin
                ctl.rf_we  = 1'b1;
                ctl.rf_src = 2'd1;
            end
            // Only Mealy term: the branch is taken straight off the ALU compare.
            BRANCH: begin
                ctl.alu_a  = 2'd1;
                ctl.alu_op = 2'b01;
                ctl.pc_src = 1'b1;
                ctl.pc_we  = ctl.zero;
            end
            JAL: begin
                ctl.pc_we  = 1'b1;
                ctl.pc_src = 1'b1;
                ctl.rf_we  = 1'b1;
                ctl.rf_src = 2'd2;
            end
            default: ;
        endcase
    end

    assign ctl.busy       = busy;
    assign ctl.instr_done = done;
    assign ctl.illegal    = illegal_q;
    assign ctl.icount     = icount_q;
    assign ctl.state      = state_q;
endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction vector table, directed corner sequences,
// then randomized run/step/opcode traffic against an instruction-level model.
module tb_mc_control;
    localparam int CNT_W = 4;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EX_R = 3, S_EX_I = 4;
    localparam int S_MEM_ADDR = 5, S_MEM_RD = 6, S_MEM_WR = 7, S_WB_ALU = 8;
    localparam int S_WB_MEM = 9, S_BRANCH = 10, S_JAL = 11, S_HALT = 12;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_control_if #(.CNT_W(CNT_W)) bus ();
    mc_control #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .ctl(bus));

    int n_vec = 0;
    int n_miss = 0;

    logic [12:0] strb;
    assign strb = {bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_a, bus.alu_b, bus.alu_op,
                   bus.mem_we, bus.rf_we, bus.rf_src};

    typedef int iq_t[$];

    typedef struct packed {
        logic [6:0]      op;
        logic            z;
        logic [3:0]      n;
        logic [5:0][3:0] seq;
        logic [1:0]      rf_cnt;
        logic [1:0]      mem_cnt;
        logic [1:0]      pc_cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Strobe pattern each state must present, straight from the state table.
    function automatic logic [12:0] exp_strb(input int s, input logic z);
        logic ir, pw, ps, mw, rw;
        logic [1:0] a, b, op, rs;
        ir = 0; pw = 0; ps = 0; mw = 0; rw = 0; a = 0; b = 0; op = 0; rs = 0;
        case (s)
            S_FETCH:    begin ir = 1; b = 2'd1; pw = 1; end
            S_DECODE:   begin a = 2'd2; b = 2'd3; end
            S_EX_R:     begin a = 2'd1; op = 2'b10; end
            S_EX_I:     begin a = 2'd1; b = 2'd2; op = 2'b10; end
            S_MEM_ADDR: begin a = 2'd1; b = 2'd2; end
            S_MEM_WR:   mw = 1;
            S_WB_ALU:   rw = 1;
            S_WB_MEM:   begin rw = 1; rs = 2'd1; end
            S_BRANCH:   begin a = 2'd1; op = 2'b01; ps = 1; pw = z; end
            S_JAL:      begin pw = 1; ps = 1; rw = 1; rs = 2'd2; end
            default: ;
        endcase
        return {ir, pw, ps, a, b, op, mw, rw, rs};
    endfunction

    // Full state walk of one instruction, FETCH first; illegal ones end in HALT.
    function automatic iq_t path(input logic [6:0] op);
        iq_t p;
        p.push_back(S_FETCH);
        p.push_back(S_DECODE);
        case (op)
            OP_R:   begin p.push_back(S_EX_R); p.push_back(S_WB_ALU); end
            OP_I:   begin p.push_back(S_EX_I); p.push_back(S_WB_ALU); end
            OP_LW:  begin p.push_back(S_MEM_ADDR); p.push_back(S_MEM_RD); p.push_back(S_WB_MEM); end
            OP_SW:  begin p.push_back(S_MEM_ADDR); p.push_back(S_MEM_WR); end
            OP_BEQ: p.push_back(S_BRANCH);
            OP_JAL: p.push_back(S_JAL);
            default: p.push_back(S_HALT);
        endcase
        return p;
    endfunction

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom_range(0, 40);
        if (r == 0) return 7'h7F;
        if (r == 1) return 7'b0110111;
        case (r % 6)
            0: return OP_R;
            1: return OP_I;
            2: return OP_LW;
            3: return OP_SW;
            4: return OP_BEQ;
            default: return OP_JAL;
        endcase
    endfunction

    logic [3:0] exp_cnt;
    int rf_c, mem_c, pc_c, done_c;
    vec_t v;

    iq_t        q;
    int         cur;
    logic       pend, pend_n, m_ill;
    logic [3:0] m_cnt;
    logic [6:0] m_op;
    logic       busy_m, done_m;
    int         halt_cyc;

    initial begin
        tbl[0] = '{op: OP_I,   z: 1'b0, n: 4'd5, seq: {4'd1, 4'd2, 4'd4,  4'd8, 4'd0, 4'd0}, rf_cnt: 2'd1, mem_cnt: 2'd0, pc_cnt: 2'd1};
        tbl[1] = '{op: OP_R,   z: 1'b0, n: 4'd5, seq: {4'd1, 4'd2, 4'd3,  4'd8, 4'd0, 4'd0}, rf_cnt: 2'd1, mem_cnt: 2'd0, pc_cnt: 2'd1};
        tbl[2] = '{op: OP_LW,  z: 1'b1, n: 4'd6, seq: {4'd1, 4'd2, 4'd5,  4'd6, 4'd9, 4'd0}, rf_cnt: 2'd1, mem_cnt: 2'd0, pc_cnt: 2'd1};
        tbl[3] = '{op: OP_SW,  z: 1'b0, n: 4'd5, seq: {4'd1, 4'd2, 4'd5,  4'd7, 4'd0, 4'd0}, rf_cnt: 2'd0, mem_cnt: 2'd1, pc_cnt: 2'd1};
        tbl[4] = '{op: OP_BEQ, z: 1'b1, n: 4'd4, seq: {4'd1, 4'd2, 4'd10, 4'd0, 4'd0, 4'd0}, rf_cnt: 2'd0, mem_cnt: 2'd0, pc_cnt: 2'd2};
        tbl[5] = '{op: OP_BEQ, z: 1'b0, n: 4'd4, seq: {4'd1, 4'd2, 4'd10, 4'd0, 4'd0, 4'd0}, rf_cnt: 2'd0, mem_cnt: 2'd0, pc_cnt: 2'd1};
        tbl[6] = '{op: OP_JAL, z: 1'b0, n: 4'd4, seq: {4'd1, 4'd2, 4'd11, 4'd0, 4'd0, 4'd0}, rf_cnt: 2'd1, mem_cnt: 2'd0, pc_cnt: 2'd2};

        rst = 1'b0;
        bus.run = 1'b0;
        bus.step = 1'b0;
        bus.opcode = 7'd0;
        bus.zero = 1'b0;
        exp_cnt = '0;

        // Reset state, then ten quiet cycles with run low.
        @(negedge clk);
        chk("rst_state", bus.state, S_IDLE);
        chk("rst_strobes", strb, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.instr_done, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_icount", bus.icount, 0);
        rst = 1'b1;
        nxt();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_state", bus.state, S_IDLE);
            chk("idle_strobes", strb, 0);
            nxt();
        end

        // One stepped instruction per table row.
        for (int t = 0; t < 7; t++) begin
            v = tbl[t];
            bus.opcode = v.op;
            bus.zero = v.z;
            bus.step = 1'b1;
            nxt();
            bus.step = 1'b0;
            rf_c = 0; mem_c = 0; pc_c = 0;
            for (int i = 0; i < int'(v.n); i++) begin
                @(negedge clk);
                chk("tbl_state", bus.state, v.seq[5-i]);
                rf_c += int'(bus.rf_we);
                mem_c += int'(bus.mem_we);
                pc_c += int'(bus.pc_we);
                nxt();
            end
            exp_cnt = exp_cnt + 4'd1;
            chk("tbl_rf_we_cycles", rf_c, v.rf_cnt);
            chk("tbl_mem_we_cycles", mem_c, v.mem_cnt);
            chk("tbl_pc_we_cycles", pc_c, v.pc_cnt);
            chk("tbl_icount", bus.icount, exp_cnt);
        end

        // lw back-to-back under run, then run dropped mid-instruction.
        bus.opcode = OP_LW;
        bus.run = 1'b1;
        nxt();
        done_c = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            case (i)
                0: chk("lw_state", bus.state, S_FETCH);
                1: chk("lw_state", bus.state, S_DECODE);
                2: chk("lw_state", bus.state, S_MEM_ADDR);
                3: chk("lw_state", bus.state, S_MEM_RD);
                4: begin
                    chk("lw_state", bus.state, S_WB_MEM);
                    chk("lw_rf_src", bus.rf_src, 1);
                end
                default: chk("lw_refetch", bus.state, S_FETCH);
            endcase
            if (i < 5) done_c += int'(bus.instr_done);
            nxt();
        end
        chk("lw_done_pulses", done_c, 1);
        bus.run = 1'b0;
        for (int i = 0; i < 4; i++) nxt();
        @(negedge clk);
        exp_cnt = exp_cnt + 4'd2;
        chk("lw_run_drop_idle", bus.state, S_IDLE);
        chk("lw_icount", bus.icount, exp_cnt);

        // beq taken then not taken under run, then a jal finishing after run drops.
        nxt();
        bus.opcode = OP_BEQ;
        bus.zero = 1'b1;
        bus.run = 1'b1;
        nxt();
        @(negedge clk); chk("beq1_state", bus.state, S_FETCH);
        nxt(); nxt();
        @(negedge clk);
        chk("beq1_state", bus.state, S_BRANCH);
        chk("beq_taken_pc_we", bus.pc_we, 1);
        chk("beq1_done", bus.instr_done, 1);
        nxt();
        @(negedge clk); chk("beq1_next_fetch", bus.state, S_FETCH);
        bus.zero = 1'b0;
        nxt(); nxt();
        @(negedge clk);
        chk("beq2_state", bus.state, S_BRANCH);
        chk("beq_not_taken_pc_we", bus.pc_we, 0);
        nxt();
        @(negedge clk); chk("beq2_next_fetch", bus.state, S_FETCH);
        bus.opcode = OP_JAL;
        bus.run = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        chk("jal_state", bus.state, S_JAL);
        chk("jal_pc_we", bus.pc_we, 1);
        chk("jal_pc_src", bus.pc_src, 1);
        chk("jal_rf_we", bus.rf_we, 1);
        chk("jal_rf_src", bus.rf_src, 2);
        nxt();
        @(negedge clk);
        exp_cnt = exp_cnt + 4'd3;
        chk("jal_then_idle", bus.state, S_IDLE);
        chk("jal_icount", bus.icount, exp_cnt);

        // Two step pulses during one R-type collapse into exactly one more instruction.
        nxt();
        bus.opcode = OP_R;
        bus.step = 1'b1;
        nxt();
        bus.step = 1'b0;
        @(negedge clk); chk("r2_state", bus.state, S_FETCH);
        nxt();
        bus.step = 1'b1;
        @(negedge clk); chk("r2_state", bus.state, S_DECODE);
        nxt();
        @(negedge clk); chk("r2_state", bus.state, S_EX_R);
        nxt();
        bus.step = 1'b0;
        @(negedge clk); chk("r2_state", bus.state, S_WB_ALU);
        nxt();
        @(negedge clk); chk("r2_pend_fetch", bus.state, S_FETCH);
        nxt(); nxt(); nxt();
        @(negedge clk); chk("r2_second_wb", bus.state, S_WB_ALU);
        nxt();
        @(negedge clk);
        exp_cnt = exp_cnt + 4'd2;
        chk("r2_idle", bus.state, S_IDLE);
        chk("r2_icount", bus.icount, exp_cnt);
        nxt();
        nxt();
        chk("r2_stays_idle", bus.state, S_IDLE);

        // Asynchronous reset in the middle of EX_R.
        bus.step = 1'b1;
        nxt();
        bus.step = 1'b0;
        nxt(); nxt();
        @(negedge clk);
        chk("rst_mid_pre_state", bus.state, S_EX_R);
        chk("rst_mid_pre_strobes", strb, exp_strb(S_EX_R, bus.zero));
        rst = 1'b0;
        #1;
        chk("rst_mid_state", bus.state, S_IDLE);
        chk("rst_mid_strobes", strb, 0);
        chk("rst_mid_icount", bus.icount, 0);
        chk("rst_mid_busy", bus.busy, 0);
        #2 rst = 1'b1;
        nxt();

        // Illegal opcode halts and ignores run/step until reset.
        bus.opcode = 7'h7F;
        bus.step = 1'b1;
        nxt();
        bus.step = 1'b0;
        nxt(); nxt();
        @(negedge clk);
        chk("ill_state", bus.state, S_HALT);
        chk("ill_flag", bus.illegal, 1);
        chk("ill_busy", bus.busy, 0);
        for (int i = 0; i < 20; i++) begin
            nxt();
            bus.run = 1'($urandom_range(0, 1));
            bus.step = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("ill_hold_state", bus.state, S_HALT);
            chk("ill_hold_flag", bus.illegal, 1);
        end
        bus.run = 1'b0;
        bus.step = 1'b0;
        rst = 1'b0;
        #1;
        chk("ill_rst_state", bus.state, S_IDLE);
        chk("ill_rst_flag", bus.illegal, 0);
        #2 rst = 1'b1;
        nxt();

        // Randomized traffic against the instruction-level model.
        cur = S_IDLE; q.delete(); pend = 0; m_ill = 0; m_cnt = '0; m_op = OP_R; halt_cyc = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            busy_m = (cur != S_IDLE) && (cur != S_HALT);
            done_m = busy_m && (q.size() == 1);
            if (cur == S_HALT) halt_cyc++;
            if (halt_cyc > 4 || $urandom_range(0, 299) == 0) begin
                rst = 1'b0;
                #1 rst = 1'b1;
                cur = S_IDLE; q.delete(); pend = 0; m_ill = 0; m_cnt = '0; halt_cyc = 0;
                busy_m = 0; done_m = 0;
            end
            if (bus.run && $urandom_range(0, 19) == 0) bus.run = 1'b0;
            else if (!bus.run && cur == S_IDLE && $urandom_range(0, 3) == 0) bus.run = 1'b1;
            bus.step = ((cur == S_IDLE) || (!bus.run && !(done_m && pend))) && ($urandom_range(0, 4) == 0);
            bus.zero = 1'($urandom_range(0, 1));
            if (cur == S_FETCH) bus.opcode = m_op;

            @(negedge clk);
            chk("rnd_state", bus.state, cur);
            chk("rnd_strobes", strb, exp_strb(cur, bus.zero));
            chk("rnd_busy", bus.busy, busy_m);
            chk("rnd_done", bus.instr_done, done_m);
            chk("rnd_illegal", bus.illegal, m_ill);
            chk("rnd_icount", bus.icount, m_cnt);

            if (done_m) m_cnt = m_cnt + 4'd1;
            pend_n = pend;
            if (cur != S_HALT) begin
                if (cur == S_IDLE || done_m) begin
                    if (bus.run || pend || (cur == S_IDLE && bus.step)) begin
                        pend_n = 0;
                        m_op = pick_op();
                        q = path(m_op);
                    end else begin
                        q.delete();
                    end
                end else begin
                    void'(q.pop_front());
                end
            end
            if (busy_m && bus.step) pend_n = 1;
            pend = pend_n;
            cur = (q.size() == 0) ? S_IDLE : q[0];
            if (cur == S_HALT) m_ill = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
